// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the opcodes known to the control decoder, and the
// miss-wait state encoding used by the hazard unit.
package cpu_pkg;

  localparam logic [6:0] R_Type = 7'b0110011;
  localparam logic [6:0] I_Type = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BEQ    = 7'b1100011;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    MISS = 1'b1
  } hz_state_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      R_Type, I_Type, LW, SW, BEQ: uses_rs1 = 1'b1;
      default:                     uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      R_Type, SW, BEQ: uses_rs2 = 1'b1;
      default:         uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  // Count qualified events, holding once full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard/stall controller: load-use bubbles, branch flushes, cache-miss
// freeze, plus performance counters and a sticky miss watchdog.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int MISS_TIMEOUT = 1023
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       ID_Op_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             Branch_taken_i,
  input  logic             Mem_stall_i,
  output logic             Stall_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFID_Flush_o,
  output logic             Freeze_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             miss_timeout_o
);

  localparam int RUN_W = $clog2(MISS_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MISS_TIMEOUT);

  hz_state_t        r_state;
  hz_state_t        w_state_nxt;
  logic [RUN_W-1:0] r_miss_run;
  logic [RUN_W-1:0] w_miss_run_nxt;
  logic             r_timeout;
  logic             w_lu;
  logic             w_lu_inc;
  logic             w_flush_inc;
  logic             w_miss_inc;

  assign w_lu = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                ((uses_rs1(ID_Op_i) && (EX_rd_i == ID_rs1_i)) ||
                 (uses_rs2(ID_Op_i) && (EX_rd_i == ID_rs2_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (Mem_stall_i) w_state_nxt = MISS;
        else             w_state_nxt = RUN;
      end
      MISS: begin
        if (Mem_stall_i) w_state_nxt = MISS;
        else             w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Freeze depends on the live miss signal, so the release cycle already runs.
  always_comb begin
    Stall_o      = 1'b0;
    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    IFID_Flush_o = 1'b0;
    Freeze_o     = 1'b0;
    if (rst_i) begin
      Stall_o     = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (Mem_stall_i) begin
      Freeze_o    = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (w_lu) begin
      Stall_o     = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (Branch_taken_i) begin
      IFID_Flush_o = 1'b1;
    end else begin
      Stall_o = 1'b0;
    end
  end

  assign w_miss_inc  = !rst_i && Mem_stall_i;
  assign w_lu_inc    = !rst_i && !Mem_stall_i && w_lu;
  assign w_flush_inc = !rst_i && !Mem_stall_i && !w_lu && Branch_taken_i;

  always_comb begin
    if (r_state == MISS) begin
      if (r_miss_run == RUN_MAX) w_miss_run_nxt = r_miss_run;
      else                       w_miss_run_nxt = r_miss_run + RUN_W'(1);
    end else begin
      w_miss_run_nxt = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_miss_run <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_miss_run <= w_miss_run_nxt;
      r_timeout  <= r_timeout | (w_miss_run_nxt == RUN_MAX);
    end
  end

  assign miss_timeout_o = r_timeout;

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_lu_inc), .cnt_o(lu_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_miss_inc), .cnt_o(miss_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_flush_inc), .cnt_o(flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios then random traffic,
// compared against a cycle-level behavioural model.
module tb_hazard_unit;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_NOP = 7'b0000000;
  localparam int TMO = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, exmr, br, ms;
  logic [6:0] op;
  logic [4:0] rs1, rs2, rd;

  logic        a_stall, a_pcw, a_ifw, a_fl, a_fr, a_to;
  logic [15:0] a_lu, a_miss, a_fc;
  logic        b_stall, b_pcw, b_ifw, b_fl, b_fr, b_to;
  logic [1:0]  b_lu, b_miss, b_fc;

  hazard_unit #(.CNT_W(16), .MISS_TIMEOUT(TMO)) dut_a (
    .clk_i(clk), .rst_i(rst), .ID_Op_i(op), .ID_rs1_i(rs1), .ID_rs2_i(rs2),
    .EX_MemRead_i(exmr), .EX_rd_i(rd), .Branch_taken_i(br), .Mem_stall_i(ms),
    .Stall_o(a_stall), .PCWrite_o(a_pcw), .IFIDWrite_o(a_ifw), .IFID_Flush_o(a_fl),
    .Freeze_o(a_fr), .lu_cnt_o(a_lu), .miss_cnt_o(a_miss), .flush_cnt_o(a_fc),
    .miss_timeout_o(a_to)
  );

  hazard_unit #(.CNT_W(2), .MISS_TIMEOUT(TMO)) dut_b (
    .clk_i(clk), .rst_i(rst), .ID_Op_i(op), .ID_rs1_i(rs1), .ID_rs2_i(rs2),
    .EX_MemRead_i(exmr), .EX_rd_i(rd), .Branch_taken_i(br), .Mem_stall_i(ms),
    .Stall_o(b_stall), .PCWrite_o(b_pcw), .IFIDWrite_o(b_ifw), .IFID_Flush_o(b_fl),
    .Freeze_o(b_fr), .lu_cnt_o(b_lu), .miss_cnt_o(b_miss), .flush_cnt_o(b_fc),
    .miss_timeout_o(b_to)
  );

  int errors = 0;
  int checks = 0;

  // Model state: what the registers should hold right now.
  int m_lu = 0, m_miss = 0, m_fc = 0;
  int m_streak = 0;   // consecutive cycles spent waiting in the miss state
  bit m_in_miss = 1'b0;
  bit m_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Apply one cycle of inputs, check everything, then advance the model across the edge.
  task automatic step(input logic r, input logic [6:0] o, input logic [4:0] s1, input logic [4:0] s2,
                      input logic mr, input logic [4:0] d, input logic b, input logic m);
    bit u1, u2, lu, e_st, e_pcw, e_ifw, e_fl, e_fr;
    rst = r; op = o; rs1 = s1; rs2 = s2; exmr = mr; rd = d; br = b; ms = m;
    #2;
    u1 = (o == OP_R) || (o == OP_I) || (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ);
    u2 = (o == OP_R) || (o == OP_SW) || (o == OP_BEQ);
    lu = mr && (d != 5'd0) && ((u1 && d == s1) || (u2 && d == s2));
    e_st = 1'b0; e_pcw = 1'b1; e_ifw = 1'b1; e_fl = 1'b0; e_fr = 1'b0;
    if (r)       begin e_st = 1'b1; e_pcw = 1'b0; e_ifw = 1'b0; end
    else if (m)  begin e_fr = 1'b1; e_pcw = 1'b0; e_ifw = 1'b0; end
    else if (lu) begin e_st = 1'b1; e_pcw = 1'b0; e_ifw = 1'b0; end
    else if (b)  begin e_fl = 1'b1; end
    check("Stall_o",      32'(a_stall), 32'(e_st));
    check("PCWrite_o",    32'(a_pcw),   32'(e_pcw));
    check("IFIDWrite_o",  32'(a_ifw),   32'(e_ifw));
    check("IFID_Flush_o", 32'(a_fl),    32'(e_fl));
    check("Freeze_o",     32'(a_fr),    32'(e_fr));
    check("lu_cnt",       32'(a_lu),    32'(sat(m_lu, 65535)));
    check("miss_cnt",     32'(a_miss),  32'(sat(m_miss, 65535)));
    check("flush_cnt",    32'(a_fc),    32'(sat(m_fc, 65535)));
    check("miss_timeout", 32'(a_to),    32'(m_to));
    check("b_flush_cnt",  32'(b_fc),    32'(sat(m_fc, 3)));
    check("b_miss_cnt",   32'(b_miss),  32'(sat(m_miss, 3)));
    if (r) begin
      m_lu = 0; m_miss = 0; m_fc = 0; m_streak = 0; m_in_miss = 1'b0; m_to = 1'b0;
    end else begin
      if (m) m_miss++;
      else if (lu) m_lu++;
      else if (b) m_fc++;
      m_streak = m_in_miss ? sat(m_streak + 1, TMO) : 0;
      if (m_streak == TMO) m_to = 1'b1;
      m_in_miss = m;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] ops [7];
    bit r_ms;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LW; ops[3] = OP_SW;
    ops[4] = OP_BEQ; ops[5] = OP_JAL; ops[6] = OP_NOP;
    rst = 1'b1; op = OP_NOP; rs1 = 5'd0; rs2 = 5'd0; exmr = 1'b0; rd = 5'd0; br = 1'b0; ms = 1'b0;
    @(negedge clk);
    // reset state
    step(1'b1, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    // load-use on rs2, one-cycle bubble
    step(1'b0, OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    step(1'b0, OP_R, 5'd1, 5'd5, 1'b0, 5'd9, 1'b0, 1'b0);
    // rd=0 and I_Type rs2 never hazard
    step(1'b0, OP_R, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    step(1'b0, OP_I, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    step(1'b0, OP_JAL, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    // taken branch, then branch masked by load-use on rs1
    step(1'b0, OP_BEQ, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b0, OP_BEQ, 5'd7, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
    step(1'b0, OP_BEQ, 5'd7, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
    // 10-cycle miss with a pending load-use, bubble on release
    for (int i = 0; i < 10; i++) step(1'b0, OP_SW, 5'd4, 5'd8, 1'b1, 5'd8, 1'b0, 1'b1);
    step(1'b0, OP_SW, 5'd4, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0);
    step(1'b0, OP_SW, 5'd4, 5'd8, 1'b0, 5'd8, 1'b0, 1'b0);
    step(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    // reset asserted mid-miss
    for (int i = 0; i < 3; i++) step(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b1, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    // watchdog: long stall, flag must stay after release
    for (int i = 0; i < 12; i++) step(1'b0, OP_LW, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, OP_LW, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    // five taken branches: the 2-bit instance holds at 3
    for (int i = 0; i < 5; i++) step(1'b0, OP_BEQ, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    // random traffic with small register numbers so matches are frequent
    r_ms = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) r_ms = ~r_ms;
      step(($urandom_range(0, 59) == 0),
           ops[$urandom_range(0, 6)],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0), r_ms);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
